// File: rtl/jzjpcc_pkg.sv
// Shared types and constants for the jzjpcc pipeline: writeback source
// select encoding and load funct3 codes.
package jzjpcc_pkg;

    typedef enum logic [1:0] {
        RD_SRC_ALU      = 2'd0,
        RD_SRC_LOAD     = 2'd1,
        RD_SRC_PC_PLUS4 = 2'd2,
        RD_SRC_IMM      = 2'd3
    } rd_source_t;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

endpackage

// File: rtl/jzjpcc_load_extract.sv
// Combinational load data extraction: picks the byte/halfword/word out of an
// aligned 32-bit memory word and sign- or zero-extends it.
module jzjpcc_load_extract
    import jzjpcc_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] data,
    output logic        misaligned,
    output logic        illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    // Misalignment is only reported for supported widths; unsupported
    // encodings report illegal alone.
    always_comb begin
        data       = '0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3)
            LOAD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            LOAD_LBU: data = {24'h000000, byte_sel};
            LOAD_LH: begin
                data       = {{16{half_sel[15]}}, half_sel};
                misaligned = offset[0];
            end
            LOAD_LHU: begin
                data       = {16'h0000, half_sel};
                misaligned = offset[0];
            end
            LOAD_LW: begin
                data       = word;
                misaligned = (offset != 2'd0);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/jzjpcc_writeback.sv
// Writeback stage: registers the memory-stage result, drives the register
// file write port, counts retired instructions and records load faults.
module jzjpcc_writeback
    import jzjpcc_pkg::*;
#(
    parameter logic [31:0] RESET_PC_PLUS4 = 32'h00000004
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_memory,
    input  logic [4:0]  rdAddr_memory,
    input  logic        rdWriteEnable_memory,
    input  logic [1:0]  rdSource_memory,
    input  logic [2:0]  funct3_memory,
    input  logic [31:0] aluResult_memory,
    input  logic [31:0] memReadData_memory,
    input  logic [31:0] pcPlus4_memory,
    input  logic [31:0] immediate_memory,
    input  logic        stall,
    input  logic        flush,
    output logic [4:0]  rdAddr_writebackEnd,
    output logic [31:0] rd_writebackEnd,
    output logic        rdWriteEnable_writebackEnd,
    output logic [63:0] instret,
    output logic        loadMisaligned,
    output logic        loadIllegal
);

    rd_source_t  source;
    logic [31:0] load_data;
    logic        load_misaligned;
    logic        load_illegal;
    logic        is_load;
    logic        live;
    logic        fault;
    logic        write_enable_next;
    logic [31:0] data_next;

    logic        valid_q;
    logic        write_enable_q;
    logic [4:0]  rd_addr_q;
    logic [31:0] data_q;
    logic [31:0] pc_plus4_q;
    logic        pc_select_q;
    logic [63:0] instret_q;
    logic        misaligned_q;
    logic        illegal_q;

    assign source = rd_source_t'(rdSource_memory);

    jzjpcc_load_extract load_extract (
        .funct3     (funct3_memory),
        .offset     (aluResult_memory[1:0]),
        .word       (memReadData_memory),
        .data       (load_data),
        .misaligned (load_misaligned),
        .illegal    (load_illegal)
    );

    // A slot only counts, writes or faults if it is valid and not being flushed.
    assign is_load           = (source == RD_SRC_LOAD);
    assign live              = valid_memory & ~flush;
    assign fault             = is_load & (load_misaligned | load_illegal);
    assign write_enable_next = live & rdWriteEnable_memory
                               & (rdAddr_memory != 5'd0) & ~fault;

    // PC+4 has its own stage register, so it is left out of the data mux.
    always_comb begin
        data_next = '0;
        case (source)
            RD_SRC_ALU:      data_next = aluResult_memory;
            RD_SRC_LOAD:     data_next = load_data;
            RD_SRC_IMM:      data_next = immediate_memory;
            RD_SRC_PC_PLUS4: data_next = '0;
            default:         data_next = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q        <= 1'b0;
            write_enable_q <= 1'b0;
            rd_addr_q      <= '0;
            data_q         <= '0;
            pc_plus4_q     <= RESET_PC_PLUS4;
            pc_select_q    <= 1'b0;
            instret_q      <= '0;
            misaligned_q   <= 1'b0;
            illegal_q      <= 1'b0;
        end else if (!stall) begin
            valid_q        <= live;
            write_enable_q <= write_enable_next;
            rd_addr_q      <= rdAddr_memory;
            data_q         <= data_next;
            pc_plus4_q     <= pcPlus4_memory;
            pc_select_q    <= (source == RD_SRC_PC_PLUS4);
            if (live) begin
                instret_q <= instret_q + 64'd1;
            end
            if (live & is_load & load_misaligned) begin
                misaligned_q <= 1'b1;
            end
            if (live & is_load & load_illegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign rdAddr_writebackEnd        = rd_addr_q;
    assign rd_writebackEnd            = pc_select_q ? pc_plus4_q : data_q;
    assign rdWriteEnable_writebackEnd = valid_q & write_enable_q;
    assign instret                    = instret_q;
    assign loadMisaligned             = misaligned_q;
    assign loadIllegal                = illegal_q;

endmodule

// File: tb/tb_jzjpcc_writeback.sv
// Directed bench for jzjpcc_writeback: a vector table for source selection and
// load extraction, then hand sequences for faults, stall/flush, reset and wrap.
module tb_jzjpcc_writeback;

    logic        clock;
    logic        reset;
    logic        valid_memory;
    logic [4:0]  rdAddr_memory;
    logic        rdWriteEnable_memory;
    logic [1:0]  rdSource_memory;
    logic [2:0]  funct3_memory;
    logic [31:0] aluResult_memory;
    logic [31:0] memReadData_memory;
    logic [31:0] pcPlus4_memory;
    logic [31:0] immediate_memory;
    logic        stall;
    logic        flush;
    logic [4:0]  rdAddr_writebackEnd;
    logic [31:0] rd_writebackEnd;
    logic        rdWriteEnable_writebackEnd;
    logic [63:0] instret;
    logic        loadMisaligned;
    logic        loadIllegal;

    int checks;
    int fails;
    logic [63:0] expInstret;

    jzjpcc_writeback dut (
        .clock                      (clock),
        .reset                      (reset),
        .valid_memory               (valid_memory),
        .rdAddr_memory              (rdAddr_memory),
        .rdWriteEnable_memory       (rdWriteEnable_memory),
        .rdSource_memory            (rdSource_memory),
        .funct3_memory              (funct3_memory),
        .aluResult_memory           (aluResult_memory),
        .memReadData_memory         (memReadData_memory),
        .pcPlus4_memory             (pcPlus4_memory),
        .immediate_memory           (immediate_memory),
        .stall                      (stall),
        .flush                      (flush),
        .rdAddr_writebackEnd        (rdAddr_writebackEnd),
        .rd_writebackEnd            (rd_writebackEnd),
        .rdWriteEnable_writebackEnd (rdWriteEnable_writebackEnd),
        .instret                    (instret),
        .loadMisaligned             (loadMisaligned),
        .loadIllegal                (loadIllegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [4:0]  addr;
        logic        wen;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic        expWe;
        logic [31:0] expRd;
    } vec_t;

    vec_t vecs[11];

    task automatic applyStimulus(input logic [1:0] src, input logic [2:0] f3,
                                 input logic [4:0] addr, input logic wen,
                                 input logic [31:0] alu, input logic [31:0] mem,
                                 input logic [31:0] pc4, input logic [31:0] imm);
        valid_memory         = 1'b1;
        rdSource_memory      = src;
        funct3_memory        = f3;
        rdAddr_memory        = addr;
        rdWriteEnable_memory = wen;
        aluResult_memory     = alu;
        memReadData_memory   = mem;
        pcPlus4_memory       = pc4;
        immediate_memory     = imm;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        expInstret = 64'd0;

        vecs[0]  = '{2'd0, 3'd0, 5'd5,  1'b1, 32'hDEADBEEF, 32'h0,         32'h0,   32'h0,         1'b1, 32'hDEADBEEF};
        vecs[1]  = '{2'd1, 3'd0, 5'd6,  1'b1, 32'h00001003, 32'h80FF1234, 32'h0,   32'h0,         1'b1, 32'hFFFFFF80};
        vecs[2]  = '{2'd1, 3'd4, 5'd6,  1'b1, 32'h00001003, 32'h80FF1234, 32'h0,   32'h0,         1'b1, 32'h00000080};
        vecs[3]  = '{2'd1, 3'd5, 5'd6,  1'b1, 32'h00001002, 32'h80FF1234, 32'h0,   32'h0,         1'b1, 32'h000080FF};
        vecs[4]  = '{2'd1, 3'd1, 5'd6,  1'b1, 32'h00001002, 32'h80FF1234, 32'h0,   32'h0,         1'b1, 32'hFFFF80FF};
        vecs[5]  = '{2'd1, 3'd0, 5'd6,  1'b1, 32'h00001001, 32'h80FF1234, 32'h0,   32'h0,         1'b1, 32'h00000012};
        vecs[6]  = '{2'd1, 3'd2, 5'd9,  1'b1, 32'h00001000, 32'h80FF1234, 32'h0,   32'h0,         1'b1, 32'h80FF1234};
        vecs[7]  = '{2'd3, 3'd0, 5'd10, 1'b1, 32'h00000000, 32'h0,         32'h0,   32'h12345000, 1'b1, 32'h12345000};
        vecs[8]  = '{2'd2, 3'd0, 5'd7,  1'b1, 32'h00000000, 32'h0,         32'h104, 32'h0,         1'b1, 32'h00000104};
        vecs[9]  = '{2'd0, 3'd0, 5'd0,  1'b1, 32'h00000001, 32'h0,         32'h0,   32'h0,         1'b0, 32'h00000001};
        vecs[10] = '{2'd0, 3'd0, 5'd3,  1'b0, 32'h00000055, 32'h0,         32'h0,   32'h0,         1'b0, 32'h00000055};

        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        applyStimulus(2'd0, 3'd0, 5'd1, 1'b1, 32'h11111111, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        checkOutput("reset_addr", 64'(rdAddr_writebackEnd), 64'd0);
        checkOutput("reset_rd", 64'(rd_writebackEnd), 64'd0);
        checkOutput("reset_we", 64'(rdWriteEnable_writebackEnd), 64'd0);
        checkOutput("reset_instret", instret, 64'd0);
        checkOutput("reset_flags", 64'({loadMisaligned, loadIllegal}), 64'd0);

        reset = 1'b1;
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].src, vecs[i].f3, vecs[i].addr, vecs[i].wen,
                          vecs[i].alu, vecs[i].mem, vecs[i].pc4, vecs[i].imm);
            tick();
            expInstret++;
            checkOutput($sformatf("vec%0d_addr", i), 64'(rdAddr_writebackEnd), 64'(vecs[i].addr));
            checkOutput($sformatf("vec%0d_we", i), 64'(rdWriteEnable_writebackEnd), 64'(vecs[i].expWe));
            if (vecs[i].expWe) begin
                checkOutput($sformatf("vec%0d_rd", i), 64'(rd_writebackEnd), 64'(vecs[i].expRd));
            end
            checkOutput($sformatf("vec%0d_instret", i), instret, expInstret);
        end
        checkOutput("table_flags", 64'({loadMisaligned, loadIllegal}), 64'd0);

        // Misaligned LW is suppressed and the flag sticks through a good load.
        applyStimulus(2'd1, 3'd2, 5'd8, 1'b1, 32'h00001002, 32'h80FF1234, 32'h0, 32'h0);
        tick();
        expInstret++;
        checkOutput("lw_mis_we", 64'(rdWriteEnable_writebackEnd), 64'd0);
        checkOutput("lw_mis_flag", 64'(loadMisaligned), 64'd1);
        checkOutput("lw_mis_illegal", 64'(loadIllegal), 64'd0);
        checkOutput("lw_mis_instret", instret, expInstret);
        applyStimulus(2'd1, 3'd2, 5'd8, 1'b1, 32'h00001004, 32'hCAFEF00D, 32'h0, 32'h0);
        tick();
        expInstret++;
        checkOutput("lw_good_we", 64'(rdWriteEnable_writebackEnd), 64'd1);
        checkOutput("lw_good_rd", 64'(rd_writebackEnd), 64'hCAFEF00D);
        checkOutput("lw_good_mis_sticky", 64'(loadMisaligned), 64'd1);

        // Unsupported funct3 on a non-load must not raise the illegal flag.
        applyStimulus(2'd0, 3'd3, 5'd8, 1'b1, 32'h00000003, 32'h0, 32'h0, 32'h0);
        tick();
        expInstret++;
        checkOutput("alu_f3_ignored", 64'(loadIllegal), 64'd0);
        applyStimulus(2'd1, 3'd3, 5'd8, 1'b1, 32'h00001000, 32'h12345678, 32'h0, 32'h0);
        tick();
        expInstret++;
        checkOutput("illegal_we", 64'(rdWriteEnable_writebackEnd), 64'd0);
        checkOutput("illegal_flag", 64'(loadIllegal), 64'd1);
        checkOutput("illegal_instret", instret, expInstret);

        // Stall holds everything, stall beats flush, then flush alone bubbles.
        applyStimulus(2'd0, 3'd0, 5'd4, 1'b1, 32'hAAAA5555, 32'h0, 32'h0, 32'h0);
        tick();
        expInstret++;
        applyStimulus(2'd0, 3'd0, 5'd11, 1'b1, 32'h11111111, 32'h0, 32'h0, 32'h0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("stall%0d_addr", i), 64'(rdAddr_writebackEnd), 64'd4);
            checkOutput($sformatf("stall%0d_rd", i), 64'(rd_writebackEnd), 64'hAAAA5555);
            checkOutput($sformatf("stall%0d_we", i), 64'(rdWriteEnable_writebackEnd), 64'd1);
            checkOutput($sformatf("stall%0d_instret", i), instret, expInstret);
        end
        flush = 1'b1;
        tick();
        checkOutput("stallflush_rd", 64'(rd_writebackEnd), 64'hAAAA5555);
        checkOutput("stallflush_we", 64'(rdWriteEnable_writebackEnd), 64'd1);
        checkOutput("stallflush_instret", instret, expInstret);
        stall = 1'b0;
        tick();
        checkOutput("flush_we", 64'(rdWriteEnable_writebackEnd), 64'd0);
        checkOutput("flush_instret", instret, expInstret);
        flush = 1'b0;
        tick();
        expInstret++;
        checkOutput("after_flush_addr", 64'(rdAddr_writebackEnd), 64'd11);
        checkOutput("after_flush_rd", 64'(rd_writebackEnd), 64'h11111111);
        checkOutput("after_flush_instret", instret, expInstret);

        // Reset wins over stall.
        stall = 1'b1;
        reset = 1'b0;
        tick();
        checkOutput("midreset_addr", 64'(rdAddr_writebackEnd), 64'd0);
        checkOutput("midreset_rd", 64'(rd_writebackEnd), 64'd0);
        checkOutput("midreset_we", 64'(rdWriteEnable_writebackEnd), 64'd0);
        checkOutput("midreset_instret", instret, 64'd0);
        checkOutput("midreset_flags", 64'({loadMisaligned, loadIllegal}), 64'd0);
        reset = 1'b1;

        // Preload the counter to all ones while stalled, then retire one.
        force dut.instret_q = 64'hFFFFFFFFFFFFFFFF;
        #1;
        release dut.instret_q;
        applyStimulus(2'd0, 3'd0, 5'd2, 1'b1, 32'h00000022, 32'h0, 32'h0, 32'h0);
        stall = 1'b0;
        tick();
        checkOutput("wrap_instret", instret, 64'd0);
        checkOutput("wrap_rd", 64'(rd_writebackEnd), 64'h22);

        $display("test done: total=%0d bad=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/jzjpcc_writeback.md
Name: jzjpcc_writeback

Overview:
Final pipeline stage and sole driver of the register file write port. It registers the memory-stage result and selects the destination value from the ALU result, load data, PC+4 or the immediate. It performs load byte/half extraction with sign or zero extension. It drives the writebackEnd write interface, which the register file commits on the following negative clock edge. It also keeps a retired-instruction counter and sticky load-fault flags.

Parameters:
RESET_PC_PLUS4, 32'h00000004, value of the internal PC+4 register after reset; unused unless the source is PC_PLUS4.

Ports:
clock  in  1  core clock; all state updates on posedge.
reset  in  1  synchronous reset, active-low (0 = reset), sampled on posedge clock.
valid_memory  in  1  memory-stage slot holds a real instruction.
rdAddr_memory  in  5  destination register.
rdWriteEnable_memory  in  1  instruction writes rd.
rdSource_memory  in  2  selects rd value: 0 ALU, 1 LOAD, 2 PC_PLUS4, 3 IMM.
funct3_memory  in  3  load width/sign: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
aluResult_memory  in  32  ALU result; also the load address.
memReadData_memory  in  32  aligned 32-bit word read from data memory.
pcPlus4_memory  in  32  PC+4 of the instruction.
immediate_memory  in  32  U-type immediate.
stall  in  1  hold the writeback register.
flush  in  1  replace the incoming instruction with a bubble.
rdAddr_writebackEnd  out  5  register file write address.
rd_writebackEnd  out  32  register file write data.
rdWriteEnable_writebackEnd  out  1  register file write strobe.
instret  out  64  count of retired instructions.
loadMisaligned  out  1  sticky flag: a misaligned load was suppressed.
loadIllegal  out  1  sticky flag: a load used an unsupported funct3.

Behaviour:
- Reset (reset==0 at posedge):
  - Stage register valid=0, rdAddr=0, data=0, PC+4=RESET_PC_PLUS4.
  - instret=0, both sticky flags=0.
  - All outputs are therefore 0 in the next cycle.
  - Reset overrides stall and flush.
- Capture:
  - At posedge with reset=1, stall=0: register the selected value, rdAddr and an effective write enable.
  - Flush=1 (with stall=0) captures a bubble: valid=0, enable=0.
  - stall=1 holds all state, including the outputs. A held write simply repeats the same value into the register file, which is harmless.
  - flush=1 with stall=1: stall wins, and the held entry is kept.
- Effective enable: valid & rdWriteEnable & (rdAddr!=0) & no load fault.
- Latency:
  - An instruction presented in cycle N appears on the writebackEnd outputs from posedge N+1.
  - The register file commits it at the negedge inside cycle N+1.
  - Decode reading that register in cycle N+1 after the negedge sees the new value.
- Source selection is combinational before the stage register:
  - ALU: aluResult.
  - PC_PLUS4: pcPlus4.
  - IMM: immediate.
  - LOAD: extraction (next item).
- Load extraction, with offset = aluResult[1:0]:
  - LB/LBU: byte at offset (offset 0 = bits 7:0), sign- or zero-extended.
  - LH/LHU: offset[1] selects the halfword; offset[0]=1 is misaligned.
  - LW: offset!=0 is misaligned.
  - Unsupported funct3 (3, 6, 7) is illegal.
- Load faults:
  - A fault suppresses the write and sets the matching sticky flag at capture.
  - Flags clear only on reset.
  - Faults on flushed or invalid slots, or when rdSource!=LOAD, are ignored.
- instret:
  - Increments by 1 at each capture of a valid, non-flushed instruction, including ones with no rd write or with a load fault.
  - Does not increment while stalled.
  - Wraps from 2^64-1 to 0.

Decomposition:
- Package jzjpcc_pkg holds:
  - enum rd_source_t {RD_SRC_ALU, RD_SRC_LOAD, RD_SRC_PC_PLUS4, RD_SRC_IMM}.
  - funct3 load constants (LOAD_LB=3'b000, LOAD_LH=3'b001, LOAD_LW=3'b010, LOAD_LBU=3'b100, LOAD_LHU=3'b101).
- One combinational sub-module, jzjpcc_load_extract (funct3, offset, word → data, misaligned, illegal), reused later by the memory stage.

Test Plan:
- Reset then release: all outputs 0, instret=0. Present ALU, rdAddr=5, aluResult=32'hDEADBEEF → next cycle rdAddr_writebackEnd=5, rd=DEADBEEF, we=1, instret=1.
- LB offset 3, word 32'h80FF_1234 → rd=32'hFFFFFF80. LBU, same inputs → 32'h00000080. LHU offset 2 → 32'h000080FF.
- LW with aluResult=32'h1002 → we=0, loadMisaligned=1 and it stays 1 through later good loads. funct3=3 → loadIllegal=1.
- rdAddr=0, ALU 32'h1 → we=0, instret still increments. PC_PLUS4 = 32'h104, rd=7 → rd=32'h104.
- stall=1 for 3 cycles with a new input pending → outputs and instret held. flush=1 together with stall=1 → entry kept. flush alone → we=0 next cycle, instret unchanged.
- reset=0 asserted mid-stream with stall=1 → outputs and flags 0 next cycle. Force instret to 2^64-1 → next retire gives 0.
